rcv_buf_handoff_ctrl: RTL and testbench
=======================================

Name: rcv_buf_handoff_ctrl

Overview:
- Ping-pong receive-buffer scheduler between the hardware receive path and NIOS2 software.
- Hands completed frames to the CPU and asserts rcv_data_ready, which is read through a PIO input.
- Releases a bank when software pulses the rcv_data_read_over PIO output.
- Stalls the receiver when both banks are occupied; counts drops and flags CPU stalls.

Parameters:
- LEN_W, 11, width of frame length in bytes.
- TIMEOUT_CYC, 50000000, cycles the CPU may hold a bank before timeout_err sets; 0 disables the timeout.
- OVF_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_done  in  1  single-cycle pulse: receiver finished writing bank rx_wr_bank.
- frame_len  in  LEN_W  length of the finished frame; valid with frame_done.
- read_over  in  1  level from the rcv_data_read_over PIO; the rising edge releases the CPU bank.
- err_clr  in  1  pulse: clear ovf_cnt and timeout_err.
- rx_wr_bank  out  1  bank the receiver must write.
- rx_enable  out  1  receiver may accept a new frame.
- rd_bank  out  1  bank currently owned by the CPU.
- rd_len  out  LEN_W  length of the frame in rd_bank.
- rcv_data_ready  out  1  CPU bank holds an unread frame (to PIO input/IRQ).
- ovf_cnt  out  OVF_W  dropped-frame count, saturating.
- timeout_err  out  1  sticky: CPU held a bank for TIMEOUT_CYC cycles.

Behaviour:
- Everything is in the clk domain. read_over is registered once and a rising edge is detected as read_over & ~read_over_q; no synchroniser is used.
- Reset values: state=EMPTY, rx_wr_bank=0, rd_bank=1, rd_len=0, rcv_data_ready=0, rx_enable=1, ovf_cnt=0, timeout_err=0, read_over_q=0, queued length=0, timer=0.
- States:
  - EMPTY: CPU owns nothing.
  - ONE: CPU owns rd_bank; the receiver fills rx_wr_bank.
  - FULL: CPU owns rd_bank; the other bank holds a queued completed frame.
- EMPTY + frame_done -> ONE:
  - rd_bank<=rx_wr_bank, rd_len<=frame_len, rx_wr_bank flips.
  - rcv_data_ready=1 on the next cycle (latency 1).
- ONE + frame_done, no release -> FULL: latch qlen<=frame_len; rx_enable=0 from the next cycle.
- ONE + release edge, no frame_done -> EMPTY: rcv_data_ready=0 next cycle.
- ONE + frame_done + release edge in the same cycle -> stay ONE:
  - Banks swap (rd_bank<=rx_wr_bank, rx_wr_bank<=old rd_bank), rd_len<=frame_len.
  - rcv_data_ready forced 0 for exactly one cycle, then 1, so edge-sensitive IRQs re-fire.
- FULL + release edge -> ONE:
  - rd_bank<=old rx_wr_bank, rd_len<=qlen, rx_wr_bank<=old rd_bank, rx_enable=1.
  - rcv_data_ready low for one cycle, then 1.
- FULL + frame_done (protocol violation, since rx_enable=0): frame is dropped, ovf_cnt+1 saturating at all-ones, no state or bank change.
- FULL + frame_done + release edge in the same cycle: the release is processed as above, the frame_done is still counted as dropped, and the queued frame is handed over.
- Release edge in EMPTY: ignored, no error.
- read_over held high: only one edge counts; it must return low before another release is recognised.
- Timer:
  - Clears on every handoff.
  - Increments while state≠EMPTY.
  - timer==TIMEOUT_CYC-1 sets timeout_err; the timer saturates.
  - Release clears the timer, not the flag.
- err_clr:
  - Clears ovf_cnt and timeout_err.
  - Simultaneous drop and err_clr -> ovf_cnt=1.
  - Simultaneous timeout and err_clr -> timeout_err=1.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; queued frames are discarded.
- rd_len and rd_bank are stable whenever rcv_data_ready=1.

Decomposition:
- Shared package:
  - State encoding localparams: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Default LEN_W.
- One natural sub-module, rcv_edge_det: registered rising-edge detector for read_over, reusable for other PIO strobes.
- The rest is a single FSM plus counters.

Test Plan:
- Reset, then frame_done with len=64 -> next cycle rcv_data_ready=1, rd_bank=0, rd_len=64, rx_wr_bank=1, rx_enable=1.
- Second frame_done (len=100), then read_over 0->1 -> rx_enable=0 after the frame; after release, ready low 1 cycle then high, rd_bank=1, rd_len=100, rx_enable=1.
- frame_done (len=20) and read_over rise in the same cycle while in ONE -> banks swap, rd_len=20, ready has a one-cycle gap, state stays ONE.
- In FULL, 300 frame_done pulses with OVF_W=8 -> ovf_cnt=255, state unchanged; err_clr -> ovf_cnt=0.
- TIMEOUT_CYC=10, hold a bank 10 cycles -> timeout_err=1 at cycle 10 and stays set after release; err_clr -> 0.
- Assert reset while in FULL -> ready=0, rx_enable=1, rd_bank=1, ovf_cnt=0 immediately; read_over held high across reset deassert -> no release is recognised.

Source files
------------

// File: rtl/rcv_buf_handoff_ctrl_pkg.sv
// rtl/rcv_buf_handoff_ctrl_pkg.sv - shared types and defaults for the receive-buffer handoff controller
//
// Purpose: state encoding and default widths shared by the handoff controller files.
// Ports:   none (package).

package rcv_buf_handoff_ctrl_pkg;

  // EMPTY: CPU owns nothing.
  // ONE:   CPU owns rd_bank, receiver fills rx_wr_bank.
  // FULL:  CPU owns rd_bank, rx_wr_bank holds a queued completed frame.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int DEF_LEN_W = 11;

endpackage

// File: rtl/rcv_buf_handoff_ctrl_edge_det.sv
// rtl/rcv_buf_handoff_ctrl_edge_det.sv - registered rising-edge detector for PIO strobes
//
// Purpose: flags the first cycle a level input is seen high after being low.
//          The input must already be in the clk domain; no synchroniser is applied.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-high reset
//   din   in   level input (e.g. rcv_data_read_over PIO)
//   rise  out  din & ~din_q, combinational from the current input

module rcv_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  // A level held high produces exactly one pulse; it must drop before re-arming.
  assign rise = din & ~din_q;

endmodule

// File: rtl/rcv_buf_handoff_ctrl.sv
// rtl/rcv_buf_handoff_ctrl.sv - ping-pong receive-buffer scheduler between receive path and CPU
//
// Purpose: hands completed frames to software, releases banks on the read-over strobe,
//          stalls the receiver when both banks are occupied, counts dropped frames and
//          flags a CPU that holds a bank for too long.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   frame_done     in   pulse: receiver finished writing bank rx_wr_bank
//   frame_len      in   length of the finished frame, valid with frame_done
//   read_over      in   level from the read-over PIO; rising edge releases the CPU bank
//   err_clr        in   pulse: clear ovf_cnt and timeout_err
//   rx_wr_bank     out  bank the receiver must write
//   rx_enable      out  receiver may accept a new frame
//   rd_bank        out  bank currently owned by the CPU
//   rd_len         out  length of the frame in rd_bank
//   rcv_data_ready out  CPU bank holds an unread frame
//   ovf_cnt        out  saturating dropped-frame count
//   timeout_err    out  sticky: CPU held a bank for TIMEOUT_CYC cycles

module rcv_buf_handoff_ctrl
  import rcv_buf_handoff_ctrl_pkg::*;
#(
  parameter int LEN_W       = DEF_LEN_W,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int OVF_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_done,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             read_over,
  input  logic             err_clr,
  output logic             rx_wr_bank,
  output logic             rx_enable,
  output logic             rd_bank,
  output logic [LEN_W-1:0] rd_len,
  output logic             rcv_data_ready,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             timeout_err
);

  localparam bit TMO_EN = (TIMEOUT_CYC > 0);
  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMO_EN ? TMR_W'(TIMEOUT_CYC - 1) : '0;

  state_t             state, state_nxt;
  logic               wr_bank_nxt, rd_bank_nxt;
  logic [LEN_W-1:0]   rd_len_nxt;
  logic [LEN_W-1:0]   qlen, qlen_nxt;
  logic               ready_nxt, rx_en_nxt;
  logic               handoff, gap, drop, release_empty;
  logic               rel;
  logic [TMR_W-1:0]   timer;
  logic               tmo_hit;

  rcv_edge_det u_rel_det (
    .clk   (clk),
    .reset (reset),
    .din   (read_over),
    .rise  (rel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_EMPTY;
      rx_wr_bank     <= 1'b0;
      rd_bank        <= 1'b1;
      rd_len         <= '0;
      qlen           <= '0;
      rcv_data_ready <= 1'b0;
      rx_enable      <= 1'b1;
    end else begin
      state          <= state_nxt;
      rx_wr_bank     <= wr_bank_nxt;
      rd_bank        <= rd_bank_nxt;
      rd_len         <= rd_len_nxt;
      qlen           <= qlen_nxt;
      rcv_data_ready <= ready_nxt;
      rx_enable      <= rx_en_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_bank_nxt   = rx_wr_bank;
    rd_bank_nxt   = rd_bank;
    rd_len_nxt    = rd_len;
    qlen_nxt      = qlen;
    handoff       = 1'b0;
    gap           = 1'b0;
    drop          = 1'b0;
    release_empty = 1'b0;

    case (state)
      ST_EMPTY: begin
        // A release while empty is meaningless and silently ignored.
        if (frame_done) begin
          state_nxt   = ST_ONE;
          rd_bank_nxt = rx_wr_bank;
          rd_len_nxt  = frame_len;
          wr_bank_nxt = ~rx_wr_bank;
          handoff     = 1'b1;
        end
      end
      ST_ONE: begin
        if (frame_done && rel) begin
          // Simultaneous release and completion: swap banks in place.
          rd_bank_nxt = rx_wr_bank;
          wr_bank_nxt = rd_bank;
          rd_len_nxt  = frame_len;
          handoff     = 1'b1;
          gap         = 1'b1;
        end else if (frame_done) begin
          state_nxt = ST_FULL;
          qlen_nxt  = frame_len;
        end else if (rel) begin
          state_nxt     = ST_EMPTY;
          release_empty = 1'b1;
        end
      end
      ST_FULL: begin
        // The receiver should be stalled here; any completion is a drop.
        drop = frame_done;
        if (rel) begin
          state_nxt   = ST_ONE;
          rd_bank_nxt = rx_wr_bank;
          wr_bank_nxt = rd_bank;
          rd_len_nxt  = qlen;
          handoff     = 1'b1;
          gap         = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase

    // The one-cycle low gap on a back-to-back handoff lets edge-triggered IRQs re-fire.
    ready_nxt = (state_nxt != ST_EMPTY) && !gap;
    rx_en_nxt = (state_nxt != ST_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      // A drop coinciding with a clear must still be recorded.
      if (err_clr) begin
        ovf_cnt <= OVF_W'(1);
      end else if (ovf_cnt != {OVF_W{1'b1}}) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end else if (err_clr) begin
      ovf_cnt <= '0;
    end
  end

  assign tmo_hit = TMO_EN && (state != ST_EMPTY) && (timer == TMR_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (handoff || release_empty) begin
      timer <= '0;
    end else if (TMO_EN && (state != ST_EMPTY) && (timer != TMR_MAX)) begin
      timer <= timer + 1'b1;
    end
  end

  // Setting wins over clearing so a timeout is never lost to a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rcv_buf_handoff_ctrl.sv
// tb/tb_rcv_buf_handoff_ctrl.sv - directed self-checking bench for rcv_buf_handoff_ctrl

module tb_rcv_buf_handoff_ctrl;

  localparam int LEN_W       = 11;
  localparam int TIMEOUT_CYC = 10;
  localparam int OVF_W       = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             read_over;
  logic             err_clr;
  logic             rx_wr_bank;
  logic             rx_enable;
  logic             rd_bank;
  logic [LEN_W-1:0] rd_len;
  logic             rcv_data_ready;
  logic [OVF_W-1:0] ovf_cnt;
  logic             timeout_err;

  int errors = 0;
  int checks = 0;

  rcv_buf_handoff_ctrl #(
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .OVF_W       (OVF_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_done     (frame_done),
    .frame_len      (frame_len),
    .read_over      (read_over),
    .err_clr        (err_clr),
    .rx_wr_bank     (rx_wr_bank),
    .rx_enable      (rx_enable),
    .rd_bank        (rd_bank),
    .rd_len         (rd_len),
    .rcv_data_ready (rcv_data_ready),
    .ovf_cnt        (ovf_cnt),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_done = 1'b0;
    frame_len  = '0;
    read_over  = 1'b0;
    err_clr    = 1'b0;
    tick();
    tick();

    chk("rst_ready", rcv_data_ready, 0);
    chk("rst_rx_en", rx_enable, 1);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_rx_wr_bank", rx_wr_bank, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_tmo", timeout_err, 0);
    reset = 1'b0;
    tick();

    // First frame: EMPTY -> ONE
    frame_done = 1'b1; frame_len = 11'd64;
    tick();
    frame_done = 1'b0;
    chk("f1_ready", rcv_data_ready, 1);
    chk("f1_rd_bank", rd_bank, 0);
    chk("f1_rd_len", rd_len, 64);
    chk("f1_rx_wr_bank", rx_wr_bank, 1);
    chk("f1_rx_en", rx_enable, 1);

    // Second frame: ONE -> FULL
    frame_done = 1'b1; frame_len = 11'd100;
    tick();
    frame_done = 1'b0;
    chk("f2_rx_en", rx_enable, 0);
    chk("f2_ready", rcv_data_ready, 1);
    chk("f2_rd_len_stable", rd_len, 64);

    // Release: FULL -> ONE with the queued frame
    read_over = 1'b1;
    tick();
    chk("rel_gap_ready", rcv_data_ready, 0);
    chk("rel_rd_bank", rd_bank, 1);
    chk("rel_rd_len", rd_len, 100);
    chk("rel_rx_wr_bank", rx_wr_bank, 0);
    chk("rel_rx_en", rx_enable, 1);
    tick();
    chk("rel_ready_back", rcv_data_ready, 1);
    read_over = 1'b0;
    tick();

    // Same-cycle completion and release in ONE: swap
    frame_done = 1'b1; frame_len = 11'd20; read_over = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("swap_gap_ready", rcv_data_ready, 0);
    chk("swap_rd_bank", rd_bank, 0);
    chk("swap_rx_wr_bank", rx_wr_bank, 1);
    chk("swap_rd_len", rd_len, 20);
    chk("swap_rx_en", rx_enable, 1);
    tick();
    chk("swap_ready_back", rcv_data_ready, 1);
    tick();
    chk("held_high_no_release", rcv_data_ready, 1);
    read_over = 1'b0;

    // Fill, then flood with drops in FULL
    frame_done = 1'b1; frame_len = 11'd33;
    tick();
    chk("full_rx_en", rx_enable, 0);
    for (int i = 0; i < 254; i++) tick();
    chk("ovf_254", ovf_cnt, 254);
    for (int i = 0; i < 46; i++) tick();
    chk("ovf_sat", ovf_cnt, 255);
    chk("ovf_state_rx_en", rx_enable, 0);
    chk("ovf_rd_bank", rd_bank, 0);
    chk("ovf_rd_len", rd_len, 20);
    frame_done = 1'b0; err_clr = 1'b1;
    tick();
    chk("ovf_clr", ovf_cnt, 0);
    frame_done = 1'b1;
    tick();
    chk("ovf_drop_and_clr", ovf_cnt, 1);
    err_clr = 1'b0;

    // FULL + drop + release together
    read_over = 1'b1; frame_len = 11'd99;
    tick();
    frame_done = 1'b0;
    chk("fr_ovf", ovf_cnt, 2);
    chk("fr_rd_bank", rd_bank, 1);
    chk("fr_rd_len", rd_len, 33);
    chk("fr_rx_wr_bank", rx_wr_bank, 0);
    chk("fr_rx_en", rx_enable, 1);
    chk("fr_ready_gap", rcv_data_ready, 0);
    tick();
    chk("fr_ready_back", rcv_data_ready, 1);
    frame_done = 1'b1; frame_len = 11'd77;
    tick();
    frame_done = 1'b0;
    chk("full2_rx_en", rx_enable, 0);

    // Asynchronous reset in FULL, with read_over held high through it
    #1;
    reset = 1'b1;
    #2;
    chk("arst_ready", rcv_data_ready, 0);
    chk("arst_rx_en", rx_enable, 1);
    chk("arst_rd_bank", rd_bank, 1);
    chk("arst_rd_len", rd_len, 0);
    chk("arst_ovf", ovf_cnt, 0);
    chk("arst_tmo", timeout_err, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_ready", rcv_data_ready, 0);
    chk("post_rst_rx_en", rx_enable, 1);

    // Handoff, then hold the bank long enough to time out
    frame_done = 1'b1; frame_len = 11'd5;
    tick();
    frame_done = 1'b0;
    chk("t_ready", rcv_data_ready, 1);
    chk("t_rd_bank", rd_bank, 0);
    tick();
    chk("t_held_no_release", rcv_data_ready, 1);
    read_over = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_before", timeout_err, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_set_over_clr", timeout_err, 1);
    read_over = 1'b1;
    tick();
    chk("tmo_release_ready", rcv_data_ready, 0);
    chk("tmo_sticky", timeout_err, 1);
    read_over = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", timeout_err, 0);
    chk("tmo_ovf_zero", ovf_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
